vector_mult_pipe: RTL
=====================

Name: vector_mult_pipe

Overview:
Element-wise unsigned vector multiplier that sits directly upstream of vectorSum in the matrix-multiply datapath. It multiplies a row vector u by a column vector v element by element and presents the product vector to vectorSum, which reduces it to one dot-product term. It is a two-register pipeline with valid/ready handshakes on both sides, full throughput and backpressure.

Parameters:
DIM, 5, number of elements per vector
W_u, 8, bit-width of each input element; each product element is 2*W_u bits

Ports:
Clock  input  1  system clock, rising-edge active
Reset  input  1  synchronous, active-high reset
in_valid  input  1  u/v pair is valid this cycle
in_ready  output  1  block can accept a u/v pair this cycle
u  input  DIM*W_u  vector u, packed as below
v  input  DIM*W_u  vector v, packed as below
out_valid  output  1  prod holds a valid product vector
out_ready  input  1  downstream (vectorSum side) accepts prod this cycle
prod  output  DIM*2*W_u  product vector, feeds vectorSum with its W_u set to 2*W_u

Behaviour:
- Interface: one clock (Clock). Reset is synchronous and active-high (Reset), sampled on the rising edge of Clock.
- Packing: element 0 occupies the MSBs.
  - Element i of u/v is at bits [(DIM-i)*W_u-1 : (DIM-1-i)*W_u].
  - Element i of prod is at bits [(DIM-i)*2*W_u-1 : (DIM-1-i)*2*W_u].
- Arithmetic: prod[i] = u[i]*v[i], unsigned, exact in 2*W_u bits. No truncation, no saturation.
- Stage 1 registers hold u, v and s1_valid. Stage 2 registers hold prod and s2_valid.
- Advance rules (combinational):
  - s2_adv = !s2_valid | out_ready
  - s1_adv = !s1_valid | s2_adv
  - in_ready = s1_adv & !Reset. There is a combinational path from out_ready to in_ready, and this is permitted.
- Stage 1 on each edge:
  - If in_valid & in_ready: load u, v and set s1_valid=1.
  - Else if s1_adv: s1_valid=0.
  - Else: hold.
- Stage 2 on each edge:
  - If s2_adv: s2_valid <= s1_valid, and prod <= products of the stage-1 operands when s1_valid=1.
  - Else: hold prod and s2_valid unchanged.
- Outputs: out_valid = s2_valid; prod is driven directly from the stage-2 register.
- Latency: with out_ready high, a pair accepted on edge N is presented with out_valid=1 after edge N+1. That is 2 register stages.
- Throughput: one vector per cycle when out_ready is held high.
- Handshake rules:
  - prod and out_valid stay stable while out_valid=1 and out_ready=0.
  - No pair is dropped or duplicated.
  - Once the pipe is full (2 pairs held), in_ready drops in the same cycle that out_ready drops.
- Simultaneous events:
  - Full pipe with out_ready=1 and in_valid=1: output transfers, stage 2 takes stage 1, and stage 1 takes the new pair, all on the same edge.
  - Pipe empty with in_valid=0: the valids stay 0 and prod holds its last value.
- Reset values: s1_valid=0, s2_valid=0, out_valid=0, prod=0, stage-1 operands=0, in_ready=0 while Reset=1.
- Reset mid-operation: in-flight pairs are discarded. The first edge after Reset deasserts may accept a new pair.
- in_valid while Reset=1 is ignored.

Test Plan:
1. Basic: DIM=5, W_u=8, u=[1,2,3,4,5], v=[5,4,3,2,1], out_ready=1 -> prod=[5,8,9,8,5] with out_valid after edge N+1. The vectorSum of this prod is 35.
2. Max values: u=v=[255,255,255,255,255] -> every prod element = 65025 (16'hFE01), with no overflow.
3. Streaming: 6 back-to-back pairs (u=[k,k,k,k,k], v=[2,2,2,2,2], k=1..6) with out_ready=1 -> in_ready stays 1, and outputs [2k,...] appear on 6 consecutive cycles in order.
4. Backpressure: hold out_ready=0 while streaming -> after 2 accepts in_ready=0, and prod stays stable at the first result. Then raise out_ready=1 -> results drain in order with none lost or duplicated.
5. Reset mid-stream: assert Reset for one edge with 2 pairs in flight -> out_valid=0, prod=0, in_ready=0 during Reset. The next pair [3,3,3,3,3]x[3,3,3,3,3] yields [9,9,9,9,9], and no stale output appears.
6. Idle: in_valid=0 for 10 cycles after a result -> out_valid=0 after that result is accepted, and prod holds its last value.

Source files
------------

// File: rtl/vector_mult_pipe.sv
// Element-wise unsigned vector multiplier feeding vectorSum: two register stages
// (operands, then products) with valid/ready handshakes, full throughput and backpressure.
module vector_mult_pipe #(
    parameter int DIM = 5,
    parameter int W_u = 8
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DIM*W_u-1:0]     u,
    input  logic [DIM*W_u-1:0]     v,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DIM*2*W_u-1:0]   prod
);

    localparam int PW = 2 * W_u;

    logic [DIM*W_u-1:0] u_q, u_d;
    logic [DIM*W_u-1:0] v_q, v_d;
    logic               s1_valid_q, s1_valid_d;
    logic               s2_valid_q, s2_valid_d;
    logic [DIM*PW-1:0]  prod_q, prod_d;
    logic [DIM*PW-1:0]  prod_calc;
    logic               s1_adv;
    logic               s2_adv;

    // Operands are widened before multiplying so the full 2*W_u-bit product is kept.
    function automatic logic [PW-1:0] mul_elem(input logic [W_u-1:0] a, input logic [W_u-1:0] b);
        return {{W_u{1'b0}}, a} * {{W_u{1'b0}}, b};
    endfunction

    for (genvar gi = 0; gi < DIM; gi++) begin : g_mul
        assign prod_calc[(DIM-1-gi)*PW +: PW] =
            mul_elem(u_q[(DIM-1-gi)*W_u +: W_u], v_q[(DIM-1-gi)*W_u +: W_u]);
    end

    always_comb begin
        // NOTE: every signal gets a default first, so no path through this block can infer a latch.
        s2_adv     = !s2_valid_q || out_ready;
        s1_adv     = !s1_valid_q || s2_adv;
        in_ready   = s1_adv && !Reset;

        u_d        = u_q;
        v_d        = v_q;
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        prod_d     = prod_q;

        if (in_valid && in_ready) begin
            u_d        = u;
            v_d        = v;
            s1_valid_d = 1'b1;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        // prod keeps its last value when a bubble moves into stage 2.
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                prod_d = prod_calc;
            end
        end
    end

    // NOTE: reset is synchronous, so it lives inside the clocked branch; state uses non-blocking writes.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            u_q        <= '0;
            v_q        <= '0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            prod_q     <= '0;
        end else begin
            u_q        <= u_d;
            v_q        <= v_d;
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            prod_q     <= prod_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign prod      = prod_q;

endmodule
